// File: rtl/count_seq_pkg.sv
// Shared types and default sizes for the counter sequencer.
package count_seq_pkg;

    localparam int unsigned DEF_WIDTH = 10;
    localparam int unsigned DEF_DIV_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } seq_state_t;

endpackage : count_seq_pkg

// File: rtl/count_seq_tick.sv
// Rate divider: counts 0..div_val and wraps, raising tick on the top count.
module count_seq_tick
    import count_seq_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clk5m,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick
);

    logic [DIV_W-1:0] r_div;
    logic             w_at_top;

    assign w_at_top = (r_div == div_val);
    assign tick     = enable && w_at_top;

    // Divider register: cleared outside RUN, wraps after the top count.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (clear) begin
            r_div <= '0;
        end else if (enable) begin
            r_div <= w_at_top ? '0 : r_div + DIV_W'(1);
        end
    end

endmodule : count_seq_tick

// File: rtl/count_seq_ctrl.sv
// Counter sequencer: loads a start value, then steps the counter toward a
// stop value at a programmable rate, with abort support.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clk5m,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] stop_val,
    input  logic             dir,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt,
    output logic             load,
    output logic             en,
    output logic             updn,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [WIDTH-1:0] r_start_q;
    logic [WIDTH-1:0] r_stop_q;
    logic             r_dir_q;
    logic [DIV_W-1:0] r_rate_q;
    logic             r_aborted;

    logic             w_tick;
    logic             w_at_stop;
    logic             w_abort_take;
    logic             w_in_run;
    logic             w_capture;

    assign w_in_run  = (r_state == S_RUN);
    assign w_at_stop = (cnt == r_stop_q);
    assign w_capture = (r_state == S_IDLE) && start;

    count_seq_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk5m   (clk5m),
        .rst_n   (rst_n),
        .clear   (!w_in_run),
        .enable  (w_in_run),
        .div_val (r_rate_q),
        .tick    (w_tick)
    );

    // State register.
    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the only combinational outputs (en/load), gated by abort.
    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_abort_take = 1'b0;
        en           = 1'b0;
        load         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                    w_abort_take = 1'b1;
                end else begin
                    en           = 1'b1;
                    load         = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                    w_abort_take = 1'b1;
                end else if (w_at_stop) begin
                    w_next_state = S_DONE;
                end else begin
                    en = w_tick;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Sequence parameters, captured only when a start is accepted in IDLE.
    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= '0;
            r_stop_q  <= '0;
            r_dir_q   <= 1'b0;
            r_rate_q  <= '0;
        end else if (w_capture) begin
            r_start_q <= start_val;
            r_stop_q  <= stop_val;
            r_dir_q   <= dir;
            r_rate_q  <= rate_div;
        end
    end

    // Aborted pulse appears in the cycle after the abort is taken.
    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort_take;
        end
    end

    assign busy    = (r_state == S_LOAD) || (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign aborted = r_aborted;
    assign updn    = r_dir_q;
    assign data_in = r_start_q;

endmodule : count_seq_ctrl

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl with a looped-back up/down counter and an event scoreboard.
module tb_count_seq_ctrl;
    import count_seq_pkg::*;

    localparam int unsigned W = DEF_WIDTH;
    localparam int unsigned D = DEF_DIV_W;

    logic         clk5m = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] start_val = '0;
    logic [W-1:0] stop_val = '0;
    logic         dir = 1'b0;
    logic [D-1:0] rate_div = '0;
    logic         abort = 1'b0;
    logic [W-1:0] cnt;
    logic         load, en, updn, busy, done, aborted;
    logic [W-1:0] data_in;

    count_seq_ctrl #(.WIDTH(W), .DIV_W(D)) dut (
        .clk5m     (clk5m),
        .rst_n     (rst_n),
        .start     (start),
        .start_val (start_val),
        .stop_val  (stop_val),
        .dir       (dir),
        .rate_div  (rate_div),
        .abort     (abort),
        .cnt       (cnt),
        .load      (load),
        .en        (en),
        .updn      (updn),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #100 clk5m = ~clk5m;

    // Loadable up/down counter, cnt looped back to the sequencer.
    always @(posedge clk5m or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (en)     cnt <= load ? data_in : (updn ? cnt - W'(1) : cnt + W'(1));
    end

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    busy_total = 0;
    string scen    = "reset";

    always @(posedge clk5m) cyc <= cyc + 1;

    typedef enum int {EV_LOAD, EV_STEP, EV_DONE, EV_ABORT} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       val;
        logic     dir;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0d, expected %0d", scen, name, act, exp);
        end
    endtask

    // Monitor: turns DUT outputs into events and compares them against the scoreboard.
    always @(negedge clk5m) begin : monitor
        ev_t      e;
        ev_kind_t k;
        bit       has;
        if (rst_n) begin
            if (busy) busy_total++;
            has = 1'b1;
            k   = EV_LOAD;
            if (load)         k = EV_LOAD;
            else if (en)      k = EV_STEP;
            else if (done)    k = EV_DONE;
            else if (aborted) k = EV_ABORT;
            else              has = 1'b0;
            if (has) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event_kind", int'(k), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", int'(k), int'(e.kind));
                    check("event_cycle", cyc, e.cyc);
                    case (e.kind)
                        EV_LOAD: begin
                            check("load_data_in", int'(data_in), e.val);
                            check("load_updn", int'(updn), int'(e.dir));
                        end
                        EV_STEP: begin
                            check("step_cnt", int'(cnt), e.val);
                            check("step_updn", int'(updn), int'(e.dir));
                        end
                        default: check("end_cnt", int'(cnt), e.val);
                    endcase
                end
            end
        end
    end

    task automatic step();
        @(posedge clk5m);
        #1;
    endtask

    task automatic push(ev_kind_t k, int c, int v, logic d);
        exp_q.push_back('{kind: k, cyc: c, val: v, dir: d});
    endtask

    // Raises start (optionally with abort) for one edge; base + k is cycle k after t0.
    task automatic launch(logic [W-1:0] sv, logic [W-1:0] pv, logic d, int r, logic a,
                          output int base);
        start_val = sv;
        stop_val  = pv;
        dir       = d;
        rate_div  = D'(r);
        abort     = a;
        start     = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        base  = cyc - 1;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            step();
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (4) step();
    endtask

    // Full sequence: expected events follow the documented cycle schedule.
    task automatic run_seq(string name, logic [W-1:0] sv, logic [W-1:0] pv, logic d, int r,
                           logic a);
        int           base;
        int           b0;
        int           n;
        logic [W-1:0] v;
        logic [W-1:0] nn;
        scen = name;
        nn   = d ? (sv - pv) : (pv - sv);
        n    = int'(nn);
        b0   = busy_total;
        launch(sv, pv, d, r, a, base);
        push(EV_LOAD, base + 1, int'(sv), d);
        v = sv;
        for (int i = 0; i < n; i++) begin
            push(EV_STEP, base + 2 + r + i * (r + 1), int'(v), d);
            v = d ? v - W'(1) : v + W'(1);
        end
        push(EV_DONE, base + n * (r + 1) + 3, int'(pv), d);
        drain();
        check("busy_cycles", busy_total - b0, n * (r + 1) + 2);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_load"},    int'(load), 0);
        check({tag, "_en"},      int'(en), 0);
        check({tag, "_busy"},    int'(busy), 0);
        check({tag, "_done"},    int'(done), 0);
        check({tag, "_aborted"}, int'(aborted), 0);
        check({tag, "_updn"},    int'(updn), 0);
        check({tag, "_data_in"}, int'(data_in), 0);
    endtask

    initial begin : watchdog
        #(200 * 5000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        int b0;

        #1;
        check_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        run_seq("up_5_8", 10'd5, 10'd8, 1'b0, 0, 1'b0);
        run_seq("up_wrap", 10'd1022, 10'd1, 1'b0, 0, 1'b0);
        run_seq("down_wrap_r3", 10'd2, 10'd1021, 1'b1, 3, 1'b0);
        run_seq("equal", 10'd7, 10'd7, 1'b0, 0, 1'b0);

        // Abort in the second RUN cycle; a second start during LOAD is ignored.
        scen = "abort";
        b0   = busy_total;
        launch(10'd5, 10'd8, 1'b0, 0, 1'b0, base);
        push(EV_LOAD, base + 1, 5, 1'b0);
        push(EV_STEP, base + 2, 5, 1'b0);
        push(EV_ABORT, base + 4, 6, 1'b0);
        start_val = 10'd100;
        stop_val  = 10'd200;
        dir       = 1'b1;
        rate_div  = D'(7);
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        abort = 1'b1;
        #1;
        check("abort_cycle_en", int'(en), 0);
        check("abort_cycle_load", int'(load), 0);
        step();
        abort = 1'b0;
        drain();
        check("abort_busy_cycles", busy_total - b0, 3);
        check("abort_cnt_frozen", int'(cnt), 6);
        check("abort_data_in_kept", int'(data_in), 5);
        check("abort_updn_kept", int'(updn), 0);
        check("abort_idle", int'(busy), 0);

        // Reset asserted mid-RUN: outputs clear immediately, no pulses.
        scen = "reset_mid_run";
        launch(10'd5, 10'd8, 1'b0, 3, 1'b0, base);
        push(EV_LOAD, base + 1, 5, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        check("midrst_cnt", int'(cnt), 0);
        step();
        step();
        check("midrst_scoreboard", exp_q.size(), 0);
        rst_n = 1'b1;
        step();

        run_seq("start_with_abort", 10'd5, 10'd8, 1'b0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_count_seq_ctrl
